// File: rtl/uart_tx_frame.sv
// UART transmit engine: accepts a parallel word and serialises it as
// start, LSB-first data, optional parity and 1-2 stop bits, one bit per CLK.
module uart_tx_frame #(
    parameter int   DATA_WIDTH = 8,
    parameter int   STOP_BITS  = 1,
    parameter logic IDLE_LVL   = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic [2:0]            dbg_state
);

    localparam int               CNT_W     = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_WIDTH - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_d;
    logic                  busy_d;
    logic                  accept;

    // Handshake: DATA_VALID is taken on a rising edge only while idle or in
    // the final stop cycle; there is no ready, and DATA_VALID is ignored otherwise.
    assign accept = DATA_VALID &&
                    ((state_q == S_IDLE) ||
                     ((state_q == S_STOP) && (stop_cnt_q == STOP_LAST)));

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        tx_d       = TX_OUT;

        if (accept) begin
            state_d    = S_START;
            shift_d    = P_DATA;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            par_en_d   = PAR_EN;
            // Parity is resolved at accept so later input changes cannot leak in.
            par_bit_d  = (^P_DATA) ^ PAR_TYP;
            tx_d       = ~IDLE_LVL;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_d = IDLE_LVL;
                end
                S_START: begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
                S_DATA: begin
                    if (bit_cnt_q == BIT_LAST) begin
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d    = S_STOP;
                            stop_cnt_d = 1'b0;
                            tx_d       = IDLE_LVL;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
                S_PARITY: begin
                    state_d    = S_STOP;
                    stop_cnt_d = 1'b0;
                    tx_d       = IDLE_LVL;
                end
                S_STOP: begin
                    tx_d = IDLE_LVL;
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tx_d    = IDLE_LVL;
                end
            endcase
        end
    end

    assign busy_d = (state_d != S_IDLE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            TX_OUT     <= IDLE_LVL;
            Busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            TX_OUT     <= tx_d;
            Busy       <= busy_d;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three lanes (8/1, 5/2, 9/2 data/stop bits) driven
// in lockstep, each checked every cycle against a frame-level reference model.
module tb_uart_tx_frame;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [8:0] p_data = '0;
  logic data_valid = 1'b0;
  logic par_en = 1'b0;
  logic par_typ = 1'b0;
  logic [N-1:0] tx_out;
  logic [N-1:0] busy;
  logic [N-1:0][2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic int frame_len(int w, int s, logic pe);
    return 1 + w + (pe ? 1 : 0) + s;
  endfunction

  // Line level for cycle idx of a frame, straight from the framing rules.
  function automatic logic frame_bit(logic [8:0] word, int w, logic pe, logic pt, int idx);
    logic [8:0] masked;
    int ones;
    masked = word & 9'((1 << w) - 1);
    ones = $countones(masked);
    if (idx == 0) return 1'b0;
    if (idx <= w) return masked[idx-1];
    if (pe && idx == w + 1) return ((ones + (pt ? 1 : 0)) % 2) == 1;
    return 1'b1;
  endfunction

  for (genvar g = 0; g < N; g++) begin : lane
    localparam int W = (g == 0) ? 8 : ((g == 1) ? 5 : 9);
    localparam int S = (g == 0) ? 1 : 2;
    logic [0:0] exp_q[$];
    logic exp_tx = 1'b1;
    logic exp_busy = 1'b0;

    uart_tx_frame #(
      .DATA_WIDTH(W),
      .STOP_BITS(S),
      .IDLE_LVL(1'b1)
    ) u_dut (
      .CLK(clk),
      .RST(rst_n),
      .P_DATA(p_data[W-1:0]),
      .DATA_VALID(data_valid),
      .PAR_EN(par_en),
      .PAR_TYP(par_typ),
      .TX_OUT(tx_out[g]),
      .Busy(busy[g]),
      .dbg_state(dbg_state[g])
    );

    // exp_q holds the line levels still to come after the current cycle.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        exp_q.delete();
        exp_tx <= 1'b1;
        exp_busy <= 1'b0;
      end else begin
        if (data_valid && exp_q.size() == 0) begin
          for (int i = 0; i < frame_len(W, S, par_en); i++)
            exp_q.push_back(frame_bit(p_data, W, par_en, par_typ, i));
        end
        if (exp_q.size() > 0) begin
          exp_tx <= exp_q.pop_front();
          exp_busy <= 1'b1;
        end else begin
          exp_tx <= 1'b1;
          exp_busy <= 1'b0;
        end
      end
    end
  end

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(string tag, logic dchk = 1'b0, logic etx = 1'b1, logic ebusy = 1'b0);
    @(negedge clk);
    chk({tag, "_tx0"}, 16'(tx_out[0]), 16'(lane[0].exp_tx));
    chk({tag, "_tx1"}, 16'(tx_out[1]), 16'(lane[1].exp_tx));
    chk({tag, "_tx2"}, 16'(tx_out[2]), 16'(lane[2].exp_tx));
    chk({tag, "_busy0"}, 16'(busy[0]), 16'(lane[0].exp_busy));
    chk({tag, "_busy1"}, 16'(busy[1]), 16'(lane[1].exp_busy));
    chk({tag, "_busy2"}, 16'(busy[2]), 16'(lane[2].exp_busy));
    if (dchk) begin
      chk({tag, "_dir_tx"}, 16'(tx_out[0]), 16'(etx));
      chk({tag, "_dir_busy"}, 16'(busy[0]), 16'(ebusy));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(string tag);
    for (int i = 0; i < 40; i++) begin
      if (busy == '0) break;
      step(tag);
    end
    chk({tag, "_idle"}, 16'(busy), 16'd0);
  endtask

  task automatic send(logic [8:0] d, logic pe, logic pt);
    p_data = d;
    par_en = pe;
    par_typ = pt;
    data_valid = 1'b1;
    step("accept", 1'b1, 1'b1, 1'b0);
    data_valid = 1'b0;
  endtask

  initial begin
    logic [10:0] seq;
    logic [19:0] seq20;

    // Reset and idle line
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", 16'(tx_out), 16'h7);
      chk("rst_busy", 16'(busy), 16'h0);
      chk("rst_state", 16'(dbg_state), 16'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) step("idle", 1'b1, 1'b1, 1'b0);

    // A5, even parity
    send(9'h0A5, 1'b1, 1'b0);
    seq = 11'b10101001010;
    for (int i = 0; i < 11; i++) step("a5", 1'b1, seq[i], 1'b1);
    step("a5_end", 1'b1, 1'b1, 1'b0);
    drain("a5");

    // 01, odd parity
    send(9'h001, 1'b1, 1'b1);
    seq = 11'b10000000010;
    for (int i = 0; i < 11; i++) step("odd01", 1'b1, seq[i], 1'b1);
    step("odd01_end", 1'b1, 1'b1, 1'b0);
    drain("odd01");

    // 01, no parity slot
    send(9'h001, 1'b0, 1'b0);
    seq = 11'b01000000010;
    for (int i = 0; i < 10; i++) step("nopar", 1'b1, seq[i], 1'b1);
    step("nopar_end", 1'b1, 1'b1, 1'b0);
    drain("nopar");

    // Held valid: 3C then C3 back to back
    p_data = 9'h03C;
    par_en = 1'b0;
    par_typ = 1'b0;
    data_valid = 1'b1;
    step("b2b_accept", 1'b1, 1'b1, 1'b0);
    seq20 = {10'b1110000110, 10'b1001111000};
    for (int i = 0; i < 20; i++) begin
      if (i == 3) p_data = 9'h0C3;
      if (i == 12) data_valid = 1'b0;
      step("b2b", 1'b1, seq20[i], 1'b1);
    end
    step("b2b_end", 1'b1, 1'b1, 1'b0);
    drain("b2b");

    // Valid pulse during DATA is ignored
    send(9'h05A, 1'b1, 1'b1);
    seq = 11'b11010110100;
    for (int i = 0; i < 11; i++) begin
      if (i == 3) begin
        p_data = 9'h1FF;
        data_valid = 1'b1;
      end
      if (i == 4) data_valid = 1'b0;
      step("ign", 1'b1, seq[i], 1'b1);
    end
    for (int i = 0; i < 4; i++) step("ign_after", 1'b1, 1'b1, 1'b0);
    drain("ign");

    // Reset during data bit 4
    send(9'h0F0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("rstmid_pre");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_tx", 16'(tx_out), 16'h7);
    chk("rstmid_busy", 16'(busy), 16'h0);
    @(posedge clk);
    #1;
    step("rstmid_hold", 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    repeat (3) step("rstmid_idle", 1'b1, 1'b1, 1'b0);
    send(9'($urandom), 1'($urandom), 1'($urandom));
    drain("rstmid_frame");

    // Randomized traffic, inputs changing freely every cycle
    for (int i = 0; i < 400; i++) begin
      data_valid = ($urandom_range(0, 3) == 0);
      p_data = 9'($urandom);
      par_en = 1'($urandom);
      par_typ = 1'($urandom);
      step("rand");
    end
    data_valid = 1'b0;
    drain("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
